// File: rtl/ram_upload.sv
// Read-back responder for the HPS ioctl upload path: serves 16-bit words of CPU work RAM
// through a byte-wide secondary RAM port while the CPU is held off the RAM.
module ram_upload #(
   parameter int unsigned AW       = 11,
   parameter int unsigned RAM_SIZE = 2048,
   parameter logic [7:0]  INDEX    = 8'd4,
   parameter int unsigned RAM_LAT  = 1
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic [26:0]   ioctl_addr,
   input  logic          ioctl_rd,
   output logic [15:0]   ioctl_din,
   output logic          ioctl_wait,
   output logic          cpu_hold,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [7:0]    ram_q
);

   localparam int unsigned   CW       = $clog2(RAM_LAT + 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LAT - 1);
   localparam logic [26:0]   SIZE_27  = 27'(RAM_SIZE);

   typedef enum logic [2:0] {
      StIdle,
      StRdLo,
      StWtLo,
      StRdHi,
      StWtHi
   } state_t;

   state_t        state_q, state_d;
   logic          pend_q, pend_d;
   logic          oor_q, oor_d;
   logic [AW-1:0] a_q, a_d;
   logic [7:0]    lo_q, lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   din_q, din_d;
   logic          wait_q, wait_d;
   logic          hold_q;
   logic [AW-1:0] raddr_q, raddr_d;
   logic          rrd_q, rrd_d;
   logic          sel;

   assign sel = ioctl_upload && (ioctl_index == INDEX);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      oor_d   = oor_q;
      a_d     = a_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      wait_d  = wait_q;
      raddr_d = raddr_q;
      rrd_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A strobe is latched first; the RAM access starts one edge later.
            if (!sel) begin
               pend_d = 1'b0;
            end else if (pend_q) begin
               pend_d = 1'b0;
               if (oor_q) begin
                  din_d = 16'hFFFF;
               end else begin
                  wait_d  = 1'b1;
                  raddr_d = a_q;
                  rrd_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = StRdLo;
               end
            end else if (ioctl_rd) begin
               pend_d = 1'b1;
               a_d    = {ioctl_addr[AW-1:1], 1'b0};
               oor_d  = (ioctl_addr >= SIZE_27);
            end
         end
         StRdLo: state_d = StWtLo;
         StWtLo: begin
            if (cnt_q == LAT_LAST) begin
               lo_d    = ram_q;
               raddr_d = {a_q[AW-1:1], 1'b1};
               rrd_d   = 1'b1;
               cnt_d   = '0;
               state_d = StRdHi;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRdHi: state_d = StWtHi;
         StWtHi: begin
            if (cnt_q == LAT_LAST) begin
               din_d   = {ram_q, lo_q};
               wait_d  = 1'b0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Losing the session abandons the request without touching the response.
      if ((state_q != StIdle) && !sel) begin
         state_d = StIdle;
         wait_d  = 1'b0;
         rrd_d   = 1'b0;
         din_d   = din_q;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         pend_q  <= 1'b0;
         oor_q   <= 1'b0;
         a_q     <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         wait_q  <= 1'b0;
         hold_q  <= 1'b0;
         raddr_q <= '0;
         rrd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         oor_q   <= oor_d;
         a_q     <= a_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         wait_q  <= wait_d;
         hold_q  <= sel;
         raddr_q <= raddr_d;
         rrd_q   <= rrd_d;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign cpu_hold   = hold_q;
   assign ram_addr   = raddr_q;
   assign ram_rd     = rrd_q;

endmodule

// File: tb/tb_ram_upload.sv
// Bench for ram_upload: two instances (RAM latency 1 and 3) driven in parallel, each with its
// own RAM model, checked against a per-request timing/data model derived from the word rules.
module tb_ram_upload;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic [26:0] ioctl_addr;
   logic        ioctl_rd;

   logic [15:0] din   [2];
   logic        wt    [2];
   logic        hold  [2];
   logic [10:0] raddr [2];
   logic        rrd   [2];
   logic [7:0]  rq    [2];

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [2048];
   logic [7:0]  p1;
   logic [7:0]  p3 [3];
   logic [15:0] exp_din [2];

   logic [15:0] s_din   [2][14];
   logic        s_wait  [2][14];
   logic        s_rd    [2][14];
   logic        s_hold  [2][14];
   logic [10:0] s_addr  [2][14];

   always #5 clk_sys = ~clk_sys;

   ram_upload #(.AW(11), .RAM_SIZE(2048), .INDEX(8'd4), .RAM_LAT(1)) u_dut1 (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_addr   (ioctl_addr),
      .ioctl_rd     (ioctl_rd),
      .ioctl_din    (din[0]),
      .ioctl_wait   (wt[0]),
      .cpu_hold     (hold[0]),
      .ram_addr     (raddr[0]),
      .ram_rd       (rrd[0]),
      .ram_q        (rq[0])
   );

   ram_upload #(.AW(11), .RAM_SIZE(2048), .INDEX(8'd4), .RAM_LAT(3)) u_dut3 (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_index  (ioctl_index),
      .ioctl_addr   (ioctl_addr),
      .ioctl_rd     (ioctl_rd),
      .ioctl_din    (din[1]),
      .ioctl_wait   (wt[1]),
      .cpu_hold     (hold[1]),
      .ram_addr     (raddr[1]),
      .ram_rd       (rrd[1]),
      .ram_q        (rq[1])
   );

   // RAM models: data only appears exactly RAM_LAT cycles after a read, junk otherwise.
   always @(posedge clk_sys) begin
      p1    <= rrd[0] ? mem[raddr[0]] : 8'($urandom);
      p3[0] <= rrd[1] ? mem[raddr[1]] : 8'($urandom);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign rq[0] = p1;
   assign rq[1] = p3[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic record(input int k);
      for (int d = 0; d < 2; d++) begin
         s_din[d][k]  = din[d];
         s_wait[d][k] = wt[d];
         s_rd[d][k]   = rrd[d];
         s_hold[d][k] = hold[d];
         s_addr[d][k] = raddr[d];
      end
   endtask

   // Issue one strobe at a negedge; edge N is the following posedge, sample k follows edge N+k.
   task automatic do_req(input logic [26:0] addr, input bit extra);
      bit          sel, inr;
      int          lat, done, nbad;
      logic [10:0] a;
      logic [15:0] nw;
      logic [15:0] ew, er, ow, orr;
      sel = ioctl_upload && (ioctl_index == 8'd4);
      inr = (addr < 27'd2048);
      a   = {addr[10:1], 1'b0};
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk_sys);
         record(k);
         ioctl_rd = 1'b0;
         if (extra && sel && inr && k == 1) begin
            ioctl_rd   = 1'b1;
            ioctl_addr = 27'($urandom_range(0, 2047));
         end
      end
      for (int d = 0; d < 2; d++) begin
         lat  = d ? 3 : 1;
         done = 2 * lat + 3;
         ew   = '0;
         er   = '0;
         nw   = exp_din[d];
         if (sel && !inr) begin
            nw   = 16'hFFFF;
            done = 1;
         end else if (sel) begin
            nw = {mem[a + 11'd1], mem[a]};
            for (int k = 1; k < done; k++) ew[k] = 1'b1;
            er[1]       = 1'b1;
            er[lat + 2] = 1'b1;
         end
         ow   = '0;
         orr  = '0;
         nbad = 0;
         for (int k = 0; k < 14; k++) begin
            ow[k]  = s_wait[d][k];
            orr[k] = s_rd[d][k];
            if (s_din[d][k] !== ((sel && k >= done) ? nw : exp_din[d])) nbad++;
         end
         check(d ? "l3_hold" : "l1_hold", 32'(s_hold[d][0]), 32'(sel));
         check(d ? "l3_wait_mask" : "l1_wait_mask", 32'(ow), 32'(ew));
         check(d ? "l3_rd_mask" : "l1_rd_mask", 32'(orr), 32'(er));
         check(d ? "l3_din" : "l1_din", 32'(s_din[d][13]), 32'(nw));
         check(d ? "l3_din_timing" : "l1_din_timing", 32'(nbad), 32'd0);
         if (sel && inr) begin
            check(d ? "l3_addr_lo" : "l1_addr_lo", 32'(s_addr[d][1]), 32'(a));
            check(d ? "l3_addr_hi" : "l1_addr_hi", 32'(s_addr[d][lat + 2]), 32'(a + 11'd1));
         end
         exp_din[d] = nw;
      end
   endtask

   // Session dropped after edge N+2 of an in-range request.
   task automatic do_drop(input logic [26:0] addr);
      logic [15:0] ow, orr;
      int          nbad;
      ioctl_addr = addr;
      ioctl_rd   = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_sys);
         record(k);
         ioctl_rd = 1'b0;
         if (k == 2) ioctl_upload = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
         ow   = '0;
         orr  = '0;
         nbad = 0;
         for (int k = 0; k < 8; k++) begin
            ow[k]  = s_wait[d][k];
            orr[k] = s_rd[d][k];
            if (s_din[d][k] !== exp_din[d]) nbad++;
         end
         check(d ? "l3_drop_wait" : "l1_drop_wait", 32'(ow), 32'h6);
         check(d ? "l3_drop_rd" : "l1_drop_rd", 32'(orr), 32'h2);
         check(d ? "l3_drop_din" : "l1_drop_din", 32'(nbad), 32'd0);
         check(d ? "l3_drop_hold_pre" : "l1_drop_hold_pre", 32'(s_hold[d][2]), 32'd1);
         check(d ? "l3_drop_hold_post" : "l1_drop_hold_post", 32'(s_hold[d][4]), 32'd0);
      end
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
   endtask

   function automatic logic [31:0] outs(input int d);
      return {1'b0, din[d], wt[d], hold[d], rrd[d], 1'b0, raddr[d]};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [26:0] ad;
      int          r;
      reset        = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_index  = 8'd0;
      ioctl_addr   = '0;
      ioctl_rd     = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      mem[11'h010] = 8'h34;
      mem[11'h011] = 8'h12;
      mem[11'h7FE] = 8'hAA;
      mem[11'h7FF] = 8'h55;
      exp_din[0] = '0;
      exp_din[1] = '0;

      repeat (3) @(negedge clk_sys);
      check("l1_reset_outs", outs(0), 32'd0);
      check("l3_reset_outs", outs(1), 32'd0);
      reset = 1'b0;
      @(negedge clk_sys);
      check("hold_idle", 32'(hold[0]), 32'd0);
      ioctl_upload = 1'b1;
      ioctl_index  = 8'd4;
      @(negedge clk_sys);
      check("hold_on", 32'(hold[0]), 32'd1);

      do_req(27'h010, 1'b0);
      do_req(27'h011, 1'b0);
      do_req(27'h7FE, 1'b0);
      do_req(27'h7FF, 1'b0);
      do_req(27'h800, 1'b0);
      do_req(27'h4000010, 1'b0);

      ioctl_index = 8'd3;
      @(negedge clk_sys);
      check("hold_idx3", 32'(hold[0]), 32'd0);
      do_req(27'h010, 1'b0);
      ioctl_index = 8'd4;
      repeat (2) @(negedge clk_sys);
      do_req(27'h010, 1'b1);

      do_drop(27'h010);

      // Reset asserted mid-request, away from any clock edge.
      ioctl_addr = 27'h7FE;
      ioctl_rd   = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      repeat (2) @(negedge clk_sys);
      @(posedge clk_sys);
      #2 reset = 1'b1;
      #1;
      check("l1_async_reset", outs(0), 32'd0);
      check("l3_async_reset", outs(1), 32'd0);
      exp_din[0] = '0;
      exp_din[1] = '0;
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      do_req(27'h010, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)       ad = 27'($urandom_range(0, 2047));
         else if (r == 6) ad = 27'h7FC + 27'($urandom_range(0, 3));
         else if (r == 7) ad = 27'h800 + 27'($urandom_range(0, 255));
         else             ad = 27'h4000000 | 27'($urandom);
         if ($urandom_range(0, 5) == 0) ioctl_index = 8'd5 + 8'($urandom_range(0, 200));
         if ($urandom_range(0, 7) == 0) ioctl_upload = 1'b0;
         if ($urandom_range(0, 3) == 0) mem[ad[10:0]] = 8'($urandom);
         @(negedge clk_sys);
         do_req(ad, 1'($urandom_range(0, 1)));
         ioctl_index  = 8'd4;
         ioctl_upload = 1'b1;
         @(negedge clk_sys);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
